dec8b10b_sync_ctrl: RTL

//  Receive-side word-alignment and link-sync controller for decoder_8b10b. Takes an unaligned
//  10-bit deserializer word stream and locates the comma at any of 10 bit offsets. Drives the

---
 rtl/dec8b10b_sync_ctrl_if.sv | 34 +++
 rtl/dec8b10b_sync_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dec8b10b_sync_ctrl_if.sv
// Bus between the 8b/10b receive sync controller, the deserializer, decoder_8b10b and the user.
interface dec8b10b_sync_ctrl_if;
  logic [9:0] din;
  logic       din_valid;
  logic [9:0] dec_din;
  logic       dec_en;
  logic       dec_rst;
  logic [7:0] dec_dout;
  logic       dec_kout;
  logic       dec_code_err;
  logic       dec_disp_err;
  logic [7:0] rx_data;
  logic       rx_k;
  logic       rx_err;
  logic       rx_valid;
  logic       sync;
  logic [3:0] align_off;
  logic [3:0] err_cnt;
  logic       realign;

  // Environment side: deserializer, decoder and user.
  modport master (
    output din, din_valid, dec_dout, dec_kout, dec_code_err, dec_disp_err,
    input  dec_din, dec_en, dec_rst, rx_data, rx_k, rx_err, rx_valid,
           sync, align_off, err_cnt, realign
  );

  // Controller side.
  modport slave (
    input  din, din_valid, dec_dout, dec_kout, dec_code_err, dec_disp_err,
    output dec_din, dec_en, dec_rst, rx_data, rx_k, rx_err, rx_valid,
           sync, align_off, err_cnt, realign
  );
endinterface

// File: rtl/dec8b10b_sync_ctrl.sv
// Comma word-alignment and link-sync controller sitting in front of decoder_8b10b.
module dec8b10b_sync_ctrl #(
  parameter int unsigned COMMAS_TO_LOCK = 3,
  parameter int unsigned ERR_MAX        = 4,
  parameter int unsigned GOOD_RUN       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dec8b10b_sync_ctrl_if.slave  bus
);
  localparam int unsigned W_WORD = 10;
  localparam int unsigned W_WIN  = 2 * W_WORD;
  localparam int unsigned W_CNT  = 4;
  localparam logic [W_CNT-1:0] LOCK_N = W_CNT'(COMMAS_TO_LOCK);
  localparam logic [W_CNT-1:0] ERR_N  = W_CNT'(ERR_MAX);
  localparam logic [W_CNT-1:0] GOOD_N = W_CNT'(GOOD_RUN);
  localparam logic [W_CNT-1:0] ONE    = W_CNT'(1);

  typedef enum logic [1:0] {ST_LOS = 2'd0, ST_CDET = 2'd1, ST_SYNC = 2'd2} state_t;

  function automatic logic is_comma(input logic [W_WORD-1:0] w);
    return (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
  endfunction

  state_t             state_q, state_d;
  logic [W_WORD-1:0]  prev_q, cur_q;
  logic [1:0]         fill_q;
  logic               new_q;
  logic [W_WIN-1:0]   win_c;
  logic               proc_c, comma_c, mis_c, to_los_c, word_bad_c;
  logic [W_CNT-1:0]   comma_off_c;
  logic [W_CNT-1:0]   align_q, align_d, cnt_q, cnt_d, err_q, err_d, good_q, good_d;
  logic [W_WORD-1:0]  dec_din_q, dec_din_d;
  logic               dec_en_q, dec_en_d, dec_rst_q;
  logic               tag1_q, tag1_d, mis1_q, mis1_d, tag2_q, tag2_d, mis2_q, mis2_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_k_q, rx_k_d, rx_err_q, rx_err_d, rx_valid_q, rx_valid_d;
  logic               sync_q, realign_q;

  assign win_c  = {prev_q, cur_q};
  assign proc_c = new_q && (fill_q == 2'd2);

  // Capture raw words into the two-word alignment window; new_q marks a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cur_q  <= '0;
      fill_q <= '0;
      new_q  <= 1'b0;
    end else begin
      new_q <= bus.din_valid;
      if (bus.din_valid) begin
        prev_q <= cur_q;
        cur_q  <= bus.din;
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      end
    end
  end

  // Comma search over all ten offsets; scanning downward lets the lowest offset win.
  always_comb begin
    comma_c     = 1'b0;
    comma_off_c = '0;
    for (int k = W_WORD - 1; k >= 0; k--) begin
      if (is_comma(W_WORD'(win_c >> (W_WORD - 32'(k))))) begin
        comma_c     = 1'b1;
        comma_off_c = W_CNT'(k);
      end
    end
  end

  // Next-state logic: comma lock in LOS/CDET, error/good bookkeeping in SYNC.
  always_comb begin
    state_d    = state_q;
    align_d    = align_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    good_d     = good_q;
    mis_c      = 1'b0;
    to_los_c   = 1'b0;
    word_bad_c = bus.dec_code_err || bus.dec_disp_err || mis2_q;
    unique case (state_q)
      ST_LOS: begin
        if (proc_c && comma_c) begin
          align_d = comma_off_c;
          cnt_d   = ONE;
          state_d = (LOCK_N <= ONE) ? ST_SYNC : ST_CDET;
        end
      end
      ST_CDET: begin
        if (proc_c && comma_c) begin
          if (comma_off_c == align_q) begin
            cnt_d = cnt_q + ONE;
            if (cnt_d >= LOCK_N) state_d = ST_SYNC;
          end else begin
            align_d = comma_off_c;
            cnt_d   = ONE;
            if (LOCK_N <= ONE) state_d = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        mis_c = proc_c && comma_c && (comma_off_c != align_q);
        if (tag2_q) begin
          if (word_bad_c) begin
            good_d = '0;
            if (err_q + ONE >= ERR_N) to_los_c = 1'b1;
            else                      err_d    = err_q + ONE;
          end else if (good_q + ONE >= GOOD_N) begin
            good_d = '0;
            if (err_q != '0) err_d = err_q - ONE;
          end else begin
            good_d = good_q + ONE;
          end
        end
        if (to_los_c) begin
          state_d = ST_LOS;
          err_d   = '0;
          good_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_LOS;
    endcase
  end

  // Decoder issue and status-tag pipeline; in-flight tags are dropped on entry to LOS.
  always_comb begin
    dec_en_d   = proc_c && (state_q != ST_LOS);
    dec_din_d  = dec_din_q;
    if (dec_en_d) dec_din_d = W_WORD'(win_c >> (W_WORD - 32'(align_d)));
    tag1_d     = dec_en_d && (state_q == ST_SYNC) && !to_los_c;
    mis1_d     = tag1_d && mis_c;
    tag2_d     = tag1_q && !to_los_c;
    mis2_d     = mis1_q && !to_los_c;
    rx_valid_d = tag2_q;
    rx_data_d  = tag2_q ? bus.dec_dout : rx_data_q;
    rx_k_d     = tag2_q ? bus.dec_kout : rx_k_q;
    rx_err_d   = tag2_q && (bus.dec_code_err || bus.dec_disp_err);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOS;
      align_q    <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      good_q     <= '0;
      dec_din_q  <= '0;
      dec_en_q   <= 1'b0;
      dec_rst_q  <= 1'b1;
      tag1_q     <= 1'b0;
      mis1_q     <= 1'b0;
      tag2_q     <= 1'b0;
      mis2_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_k_q     <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      sync_q     <= 1'b0;
      realign_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      align_q    <= align_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      good_q     <= good_d;
      dec_din_q  <= dec_din_d;
      dec_en_q   <= dec_en_d;
      dec_rst_q  <= (state_d == ST_LOS);
      tag1_q     <= tag1_d;
      mis1_q     <= mis1_d;
      tag2_q     <= tag2_d;
      mis2_q     <= mis2_d;
      rx_data_q  <= rx_data_d;
      rx_k_q     <= rx_k_d;
      rx_err_q   <= rx_err_d;
      rx_valid_q <= rx_valid_d;
      sync_q     <= (state_d == ST_SYNC);
      realign_q  <= to_los_c;
    end
  end

  assign bus.dec_din   = dec_din_q;
  assign bus.dec_en    = dec_en_q;
  assign bus.dec_rst   = dec_rst_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_k      = rx_k_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.sync      = sync_q;
  assign bus.align_off = align_q;
  assign bus.err_cnt   = err_q;
  assign bus.realign   = realign_q;
endmodule
